control_sequencer: RTL and testbench
====================================

# control_sequencer

Fetch/decode/execute sequencer for the 8-bit CPU datapath, directly upstream of the 3-to-8 opcode decoder. It fetches instructions over a req/ack memory handshake, holds them in an instruction register, and drives the decoder's enable and 3-bit select so that exactly one functional-unit select line is active during each execute phase. It also owns the program counter, jump and halt handling, and execute-stage stalling.

## Interface
- ADDR_W, 8: program counter / memory address width; must be ≥ 5.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; leaves IDLE or HALT and begins fetching.
- mem_req  out  1  fetch request, held until acknowledged.
- mem_addr  out  ADDR_W  fetch address, equal to PC.
- mem_ack  in  1  memory has valid mem_rdata this cycle.
- mem_rdata  in  8  instruction word: [7:5] opcode, [4:0] operand.
- busy  in  1  selected unit needs more cycles; stalls EXECUTE.
- dec_en  out  1  enable to the 3-to-8 decoder.
- dec_sel  out  3  opcode select to the decoder, equal to IR[7:5].
- operand  out  5  IR[4:0], for the selected unit.
- halted  out  1  high while in HALT.

## Operation
- States:
  - IDLE (reset state).
  - FETCH.
  - DECODE.
  - EXECUTE.
  - HALT.
- IDLE / HALT:
  - With start=1, go to FETCH next cycle.
  - With start=0, remain.
  - PC is not changed on exit, so HALT resumes at the instruction after HLT.
- FETCH:
  - mem_req=1 and mem_addr=PC, both stable until ack.
  - On a cycle with mem_ack=1: IR←mem_rdata, PC←PC+1 (modulo 2^ADDR_W, wrapping from all-ones to 0), go to DECODE.
  - With mem_ack=0, remain in FETCH.
- DECODE:
  - One cycle; dec_sel and operand are already valid from IR.
  - Next state is EXECUTE.
- EXECUTE:
  - dec_en=1 for every cycle spent in this state.
  - With busy=1, remain in EXECUTE.
  - With busy=0, exit according to the opcode:
    - opcode 6 (JMP): PC←zero-extended operand, then FETCH.
    - opcode 7 (HLT): go to HALT.
    - All other opcodes: go to FETCH.
  - JMP and HLT still pulse dec_en, so the decoder's line 6 or 7 is visible downstream.
- Ignored inputs:
  - mem_ack outside FETCH is ignored.
  - start outside IDLE/HALT is ignored.
  - busy outside EXECUTE is ignored.
- Outputs in IDLE, HALT, FETCH and DECODE: dec_en=0.

## Timing
- Reset values (applied immediately on rst_n low, asynchronously):
  - state=IDLE, PC=0, IR=0.
  - mem_req=0, mem_addr=0, dec_en=0, dec_sel=0, operand=0, halted=0.
- All outputs are decoded from registered state/PC/IR only; there is no combinational path from any input to any output.
- Minimum instruction time is 3 cycles: FETCH with same-cycle ack, DECODE, EXECUTE with busy=0.
- Each cycle of ack wait adds 1 cycle; each cycle of busy=1 adds 1 cycle.
- Handshake:
  - mem_ack may be high in the first FETCH cycle; it is sampled at the rising edge.
  - mem_req falls in the cycle after the ack edge (state is DECODE).
- If reset asserts mid-fetch or mid-execute, mem_req and dec_en drop immediately; no IR/PC update happens.
- halted rises in the cycle after the HLT exit edge, and falls in the cycle after the start edge.
- JMP to the current PC (a self-loop) is legal and repeats indefinitely.

## Structure
- Shared package contents:
  - State encoding: 3-bit enum IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, HALT=4.
  - Opcode constants OP_JMP=3'd6 and OP_HLT=3'd7.
  - Field positions: OPC_MSB=7, OPC_LSB=5, OPD_W=5.
- Single module, with no sub-modules.
- The 3-to-8 decoder is instantiated beside this block by the parent, connected via dec_en → E and dec_sel → A.

## Test plan
- Reset then start=1, memory acks immediately with words 0x25, 0x41:
  - First fetch is at mem_addr 0; second fetch is at mem_addr 1.
  - dec_sel=1, operand=5, dec_en high exactly 1 cycle at cycle 3 after start.
- Memory delays ack by 4 cycles: mem_req and mem_addr stay stable for 5 cycles, and PC increments once.
- Instruction 0x4A with busy high for 3 EXECUTE cycles: dec_en high for 4 consecutive cycles with dec_sel=2, then next fetch from PC+1.
- JMP 0xD3 at address 0: next mem_addr=0x13. With PC=0xFF and a non-JMP instruction, the next fetch is at 0x00.
- HLT 0xE0 at address 2:
  - dec_sel=7 with a 1-cycle dec_en, then halted=1 and mem_req=0 indefinitely.
  - start=1 then resumes fetching at address 3.
- Assert rst_n low while mem_req=1 and again while dec_en=1: both drop in the same cycle, and all outputs are at reset values before the next clock edge.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the fetch/decode/execute sequencer: state encoding,
// special opcodes and instruction-word field positions.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    HALT    = 3'd4
  } state_e;

  localparam logic [2:0] OP_JMP = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;
  localparam int OPD_W   = 5;

endpackage

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer driving the 3-to-8 opcode decoder; owns the
// PC, instruction register, jump/halt handling and execute-stage stalls.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic              busy,
  output logic              dec_en,
  output logic [2:0]        dec_sel,
  output logic [4:0]        operand,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [2:0]        opcode;

  assign opcode = ir_q[OPC_MSB:OPC_LSB];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE, HALT: begin
        // PC is left alone so a resume after HLT continues with the next word.
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        if (!busy) begin
          case (opcode)
            OP_JMP: begin
              pc_d    = {{(ADDR_W-OPD_W){1'b0}}, ir_q[OPD_W-1:0]};
              state_d = FETCH;
            end
            OP_HLT:  state_d = HALT;
            default: state_d = FETCH;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign mem_req  = (state_q == FETCH);
  assign mem_addr = pc_q;
  assign dec_en   = (state_q == EXECUTE);
  assign dec_sel  = opcode;
  assign operand  = ir_q[OPD_W-1:0];
  assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios followed by
// randomized instruction streams, checked against an instruction-level model.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, mem_ack, busy;
  logic       mem_req, dec_en, halted;
  logic [7:0] mem_addr, mem_rdata;
  logic [2:0] dec_sel;
  logic [4:0] operand;

  int         errs = 0;
  int         checks = 0;
  logic [7:0] pc_m;

  always #5 clk = ~clk;

  control_sequencer #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .dec_en    (dec_en),
    .dec_sel   (dec_sel),
    .operand   (operand),
    .halted    (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},    mem_req,  0);
    check_eq({tag, "_addr"},   mem_addr, 0);
    check_eq({tag, "_en"},     dec_en,   0);
    check_eq({tag, "_sel"},    dec_sel,  0);
    check_eq({tag, "_opd"},    operand,  0);
    check_eq({tag, "_halted"}, halted,   0);
  endtask

  // Leave reset, check IDLE, then start fetching from address 0.
  task automatic release_and_start();
    tick();
    rst_n = 1'b1;
    pc_m  = 8'h00;
    check_eq("idle_req", mem_req, 0);
    check_eq("idle_halted", halted, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic reset_now(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    mem_ack = 1'b0;
    busy    = 1'b0;
    start   = 1'b0;
    release_and_start();
  endtask

  // One whole instruction: fetch with ack delay, decode, execute with busy cycles.
  task automatic run_instr(input logic [7:0] word, input int ackdly, input int busyn);
    logic [2:0] opc;
    opc = word[7:5];
    for (int i = 0; i < ackdly; i++) begin
      mem_ack = 1'b0; mem_rdata = 8'($urandom);
      busy = 1'($urandom); start = 1'($urandom);
      check_eq("fetch_wait_req", mem_req, 1);
      check_eq("fetch_wait_addr", mem_addr, pc_m);
      tick();
    end
    check_eq("fetch_req", mem_req, 1);
    check_eq("fetch_addr", mem_addr, pc_m);
    check_eq("fetch_en", dec_en, 0);
    mem_ack = 1'b1; mem_rdata = word;
    busy = 1'($urandom); start = 1'($urandom);
    tick();
    pc_m = pc_m + 8'd1;

    mem_ack = 1'($urandom); mem_rdata = 8'($urandom);
    busy = 1'($urandom); start = 1'($urandom);
    check_eq("decode_req", mem_req, 0);
    check_eq("decode_en", dec_en, 0);
    check_eq("decode_sel", dec_sel, opc);
    check_eq("decode_opd", operand, word[4:0]);
    tick();

    for (int i = 0; i < busyn; i++) begin
      busy = 1'b1; mem_ack = 1'($urandom); start = 1'($urandom);
      check_eq("exec_busy_en", dec_en, 1);
      check_eq("exec_busy_sel", dec_sel, opc);
      tick();
    end
    busy = 1'b0; mem_ack = 1'($urandom); start = 1'($urandom);
    check_eq("exec_en", dec_en, 1);
    check_eq("exec_sel", dec_sel, opc);
    check_eq("exec_req", mem_req, 0);
    tick();
    mem_ack = 1'b0; start = 1'b0; busy = 1'b0;

    if (opc == 3'd6) pc_m = {3'b000, word[4:0]};
    if (opc == 3'd7) begin
      for (int k = 0; k < 3; k++) begin
        mem_ack = 1'($urandom); busy = 1'($urandom);
        check_eq("halt_halted", halted, 1);
        check_eq("halt_req", mem_req, 0);
        check_eq("halt_en", dec_en, 0);
        tick();
      end
      mem_ack = 1'b0; busy = 1'b0;
      start = 1'b1;
      check_eq("halt_before_start", halted, 1);
      tick();
      start = 1'b0;
      check_eq("resume_halted", halted, 0);
      check_eq("resume_req", mem_req, 1);
    end
  endtask

  initial begin
    logic [7:0] w;
    rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0; busy = 1'b0; mem_rdata = 8'h00;
    pc_m = 8'h00;
    #1;
    check_reset_outputs("por");
    release_and_start();

    // Directed scenarios.
    run_instr(8'h25, 0, 0);
    run_instr(8'h41, 0, 0);
    run_instr(8'hE0, 0, 0);              // HLT at address 2, resume at 3
    run_instr(8'h4A, 4, 3);              // long ack wait and stalled execute

    // Reset while a fetch request is outstanding.
    check_eq("pre_reset_req", mem_req, 1);
    reset_now("rst_fetch");

    run_instr(8'hD3, 0, 0);              // JMP 0x13 from address 0
    check_eq("jmp_target", mem_addr, 8'h13);
    run_instr(8'hD3, 1, 1);              // self-loop jump repeats
    check_eq("jmp_selfloop", mem_addr, 8'h13);

    // Randomized instruction stream; jumps and halts kept rare.
    for (int n = 0; n < 200; n++) begin
      w = 8'($urandom);
      if (w[7:5] == 3'd6 && ($urandom % 6) != 0) w[7:5] = 3'd1;
      if (w[7:5] == 3'd7 && ($urandom % 10) != 0) w[7:5] = 3'd2;
      run_instr(w, int'($urandom % 4), int'($urandom % 4));
    end

    // Walk the PC up to 0xFF and across the wrap.
    for (int n = 0; n < 300 && pc_m != 8'hFF; n++) begin
      w = 8'($urandom);
      w[7:5] = 3'($urandom % 6);
      run_instr(w, int'($urandom % 2), 0);
    end
    check_eq("reached_ff", mem_addr, 8'hFF);
    run_instr(8'h3C, 0, 0);
    check_eq("pc_wrap", mem_addr, 8'h00);

    // Reset while the decoder enable is active.
    mem_ack = 1'b1; mem_rdata = 8'h6B;
    tick();
    mem_ack = 1'b0;
    tick();
    busy = 1'b1;
    check_eq("pre_reset_en", dec_en, 1);
    reset_now("rst_exec");
    run_instr(8'h01, 0, 0);
    check_eq("post_reset_addr", mem_addr, 8'h01);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
